// File: rtl/mrr_pathway_stream_merge.sv
// ---------------------------------------------------------------------------
// mrr_pathway_stream_merge
//
// Merges NUM_PATHWAYS per-pathway 32-bit packet streams from the MRR gateway
// loopback/decode pathways into one AXI-Stream output. Arbitration is
// round-robin and packet-atomic: once a pathway is granted it keeps the
// output until its packet ends. A beat-count guard force-terminates packets
// longer than MAX_PKT_BEATS so a stuck pathway cannot monopolise the output.
//
// Optional feature macro: MRR_MERGE_TAG_EN
//   defined   - every packet is prefixed with a tag word
//               {8'hA5, pathway index, 16-bit per-pathway sequence number}
//   undefined - packets pass through byte-identical, no tag, no counters
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   i_tdata            per-pathway data, pathway p at [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH]
//   i_tkeep/i_tlast    per-pathway keep / end of packet
//   i_tvalid/i_tready  per-pathway handshake
//   o_tdata/o_tkeep    merged data / keep
//   o_tlast            merged end of packet (forced on truncation)
//   o_tvalid/o_tready  merged handshake
//   o_grant            one-hot grant of the packet in progress, zero in IDLE
//   o_truncate         one-cycle pulse on forced packet termination
//   o_truncate_count   saturating count of truncations
// ---------------------------------------------------------------------------
module mrr_pathway_stream_merge #(
    parameter int NUM_PATHWAYS      = 4,
    parameter int PATHWAY_IDX_WIDTH = 2,
    parameter int DATA_WIDTH        = 32,
    parameter int MAX_PKT_BEATS     = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
    input  logic [NUM_PATHWAYS-1:0]            i_tkeep,
    input  logic [NUM_PATHWAYS-1:0]            i_tlast,
    input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
    output logic [NUM_PATHWAYS-1:0]            i_tready,
    output logic [DATA_WIDTH-1:0]              o_tdata,
    output logic                               o_tkeep,
    output logic                               o_tlast,
    output logic                               o_tvalid,
    input  logic                               o_tready,
    output logic [NUM_PATHWAYS-1:0]            o_grant,
    output logic                               o_truncate,
    output logic [15:0]                        o_truncate_count
);

    localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TAG  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]                   r_state;
    logic [NUM_PATHWAYS-1:0]      r_grant;
    // Index of the current (or most recent) grant; doubles as last_grant.
    logic [PATHWAY_IDX_WIDTH-1:0] r_gidx;
    logic [CNT_W-1:0]             r_beat_cnt;
    logic [DATA_WIDTH-1:0]        r_tdata;
    logic                         r_tkeep;
    logic                         r_tlast;
    logic                         r_tvalid;
    logic                         r_truncate;
    logic [15:0]                  r_trunc_cnt;

    logic [DATA_WIDTH-1:0]        w_data_arr [NUM_PATHWAYS];
    logic                         w_out_free;
    logic                         w_found;
    logic [PATHWAY_IDX_WIDTH-1:0] w_pick;
    logic [PATHWAY_IDX_WIDTH-1:0] w_cand;
    logic                         w_accept;
    logic                         w_sel_last;
    logic                         w_beat_max;
    logic                         w_trunc;

    // Output register can take a new word when empty or being drained.
    assign w_out_free = !r_tvalid || o_tready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PATHWAYS; gi++) begin : g_path
            assign w_data_arr[gi] = i_tdata[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
            assign i_tready[gi]   = (r_state == ST_DATA) && r_grant[gi] && w_out_free;
        end
    endgenerate

    // Round-robin search starting just above the previous grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PATHWAYS; k++) begin
            w_cand = PATHWAY_IDX_WIDTH'((int'(r_gidx) + 1 + k) % NUM_PATHWAYS);
            if (!w_found && i_tvalid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_sel_last = i_tlast[r_gidx];
    assign w_accept   = (r_state == ST_DATA) && i_tvalid[r_gidx] && w_out_free;
    // The beat being accepted now is beat number MAX_PKT_BEATS.
    assign w_beat_max = (r_beat_cnt == CNT_W'(MAX_PKT_BEATS - 1));
    assign w_trunc    = w_accept && w_beat_max && !w_sel_last;

`ifdef MRR_MERGE_TAG_EN
    logic [15:0]           r_seq [NUM_PATHWAYS];
    logic [DATA_WIDTH-1:0] w_tag;

    always_comb begin
        w_tag       = '0;
        w_tag[31:0] = {8'hA5, 8'(r_gidx), r_seq[r_gidx]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PATHWAYS; p++) begin
                r_seq[p] <= 16'd0;
            end
        end else if (r_state == ST_TAG && w_out_free) begin
            r_seq[r_gidx] <= r_seq[r_gidx] + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= PATHWAY_IDX_WIDTH'(NUM_PATHWAYS - 1);
            r_beat_cnt  <= '0;
            r_tdata     <= '0;
            r_tkeep     <= 1'b0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_truncate  <= 1'b0;
            r_trunc_cnt <= 16'd0;
        end else begin
            r_truncate <= 1'b0;
            // Drain; a load below in the same cycle overrides this.
            if (r_tvalid && o_tready) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant    <= NUM_PATHWAYS'(1) << w_pick;
                        r_gidx     <= w_pick;
                        r_beat_cnt <= '0;
`ifdef MRR_MERGE_TAG_EN
                        r_state    <= ST_TAG;
`else
                        r_state    <= ST_DATA;
`endif
                    end
                end
`ifdef MRR_MERGE_TAG_EN
                ST_TAG: begin
                    if (w_out_free) begin
                        r_tdata  <= w_tag;
                        r_tkeep  <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (w_accept) begin
                        r_tdata    <= w_data_arr[r_gidx];
                        r_tkeep    <= i_tkeep[r_gidx];
                        r_tlast    <= w_sel_last || w_beat_max;
                        r_tvalid   <= 1'b1;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_sel_last || w_beat_max) begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                        if (w_trunc) begin
                            r_truncate <= 1'b1;
                            if (r_trunc_cnt != 16'hFFFF) begin
                                r_trunc_cnt <= r_trunc_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_tdata          = r_tdata;
    assign o_tkeep          = r_tkeep;
    assign o_tlast          = r_tlast;
    assign o_tvalid         = r_tvalid;
    assign o_grant          = r_grant;
    assign o_truncate       = r_truncate;
    assign o_truncate_count = r_trunc_cnt;

endmodule

// File: tb/tb_mrr_pathway_stream_merge.sv
// ---------------------------------------------------------------------------
// Testbench for mrr_pathway_stream_merge. Two instances share the input
// buses: dut_a (MAX_PKT_BEATS=16) for normal traffic and dut_t
// (MAX_PKT_BEATS=4) for truncation; 'sel' picks which one the sources and
// monitor talk to. Tag expectations follow MRR_MERGE_TAG_EN.
// ---------------------------------------------------------------------------
module tb_mrr_pathway_stream_merge;

`ifdef MRR_MERGE_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] in_tdata;
    logic [3:0]   in_tkeep, in_tlast, in_tvalid;
    logic         o_rdy;
    logic         sel;

    logic [3:0]  a_rdy, t_rdy, a_grant, t_grant;
    logic [31:0] a_tdata, t_tdata;
    logic        a_tkeep, t_tkeep, a_tlast, t_tlast, a_tvalid, t_tvalid, a_trunc, t_trunc;
    logic [15:0] a_tcnt, t_tcnt;

    mrr_pathway_stream_merge #(.NUM_PATHWAYS(4), .PATHWAY_IDX_WIDTH(2), .DATA_WIDTH(32), .MAX_PKT_BEATS(16)) dut_a (
        .clk(clk), .rst(rst), .i_tdata(in_tdata), .i_tkeep(in_tkeep), .i_tlast(in_tlast),
        .i_tvalid(in_tvalid), .i_tready(a_rdy), .o_tdata(a_tdata), .o_tkeep(a_tkeep),
        .o_tlast(a_tlast), .o_tvalid(a_tvalid), .o_tready(o_rdy), .o_grant(a_grant),
        .o_truncate(a_trunc), .o_truncate_count(a_tcnt));

    mrr_pathway_stream_merge #(.NUM_PATHWAYS(4), .PATHWAY_IDX_WIDTH(2), .DATA_WIDTH(32), .MAX_PKT_BEATS(4)) dut_t (
        .clk(clk), .rst(rst), .i_tdata(in_tdata), .i_tkeep(in_tkeep), .i_tlast(in_tlast),
        .i_tvalid(in_tvalid), .i_tready(t_rdy), .o_tdata(t_tdata), .o_tkeep(t_tkeep),
        .o_tlast(t_tlast), .o_tvalid(t_tvalid), .o_tready(o_rdy), .o_grant(t_grant),
        .o_truncate(t_trunc), .o_truncate_count(t_tcnt));

    wire [3:0]  m_rdy   = sel ? t_rdy   : a_rdy;
    wire [3:0]  m_grant = sel ? t_grant : a_grant;
    wire [31:0] m_tdata = sel ? t_tdata : a_tdata;
    wire        m_tkeep = sel ? t_tkeep : a_tkeep;
    wire        m_tlast = sel ? t_tlast : a_tlast;
    wire        m_tvalid= sel ? t_tvalid: a_tvalid;
    wire        m_trunc = sel ? t_trunc : a_trunc;
    wire [15:0] m_tcnt  = sel ? t_tcnt  : a_tcnt;

    // Entries are {keep, last, data}.
    logic [33:0] src_q [4][$];
    logic [33:0] exp_q [$];
    logic [33:0] obs_q [$];
    logic [3:0]  gnt_q [$];
    logic [15:0] exp_seq [4];

    int tests = 0;
    int fails = 0;
    int cyc, tv_cyc, first_vld, stall_viol, stall_cycles, trunc_pulses, bp_cnt;
    logic bp_mode;

    // Source driver and output monitor.
    initial begin : drive_mon
        logic [3:0]  hs;
        logic [33:0] stall_word;
        logic        stall_pend;
        logic [3:0]  prev_g;
        stall_pend = 1'b0; stall_word = '0; prev_g = '0; cyc = 0; bp_cnt = 0;
        tv_cyc = -1; first_vld = -1; stall_viol = 0; stall_cycles = 0; trunc_pulses = 0;
        in_tvalid = '0; in_tdata = '0; in_tkeep = '0; in_tlast = '0; o_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int p = 0; p < 4; p++) src_q[p].delete();
                obs_q.delete(); gnt_q.delete();
                tv_cyc = -1; first_vld = -1; stall_viol = 0; stall_cycles = 0; trunc_pulses = 0;
                stall_pend = 1'b0; prev_g = '0;
            end
            hs = in_tvalid & m_rdy;
            if (stall_pend && (!m_tvalid || {m_tkeep, m_tlast, m_tdata} != stall_word)) stall_viol++;
            stall_pend = m_tvalid && !o_rdy;
            stall_word = {m_tkeep, m_tlast, m_tdata};
            if (stall_pend) stall_cycles++;
            if (m_tvalid && o_rdy) obs_q.push_back({m_tkeep, m_tlast, m_tdata});
            if (m_trunc) trunc_pulses++;
            if (m_grant != 4'd0 && prev_g == 4'd0) gnt_q.push_back(m_grant);
            prev_g = m_grant;
            if (m_tvalid && first_vld < 0) first_vld = cyc;
            @(posedge clk);
            cyc++;
            #1;
            for (int p = 0; p < 4; p++) begin
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    {in_tkeep[p], in_tlast[p], in_tdata[32*p +: 32]} = src_q[p][0];
                    in_tvalid[p] = 1'b1;
                end else begin
                    in_tvalid[p] = 1'b0;
                end
            end
            if (in_tvalid != 4'd0 && tv_cyc < 0) tv_cyc = cyc;
            bp_cnt++;
            o_rdy = bp_mode ? (bp_cnt % 3 == 0) : 1'b1;
        end
    end

    // Queue a packet at pathway p and push the expected merged output,
    // splitting into chunks of maxb beats where the guard truncates.
    task automatic send(input int p, input int n, input logic [31:0] base,
                        input logic [31:0] step, input int maxb);
        int b, chunk;
        for (int i = 0; i < n; i++)
            src_q[p].push_back({1'(i % 3 != 2), 1'(i == n - 1), base + step * i});
        b = 0;
        while (b < n) begin
            if (TAG_EN != 0) begin
                exp_q.push_back({1'b1, 1'b0, 8'hA5, 8'(p), exp_seq[p]});
                exp_seq[p] = exp_seq[p] + 16'd1;
            end
            chunk = (n - b < maxb) ? n - b : maxb;
            for (int j = 0; j < chunk; j++)
                exp_q.push_back({1'((b + j) % 3 != 2), 1'(j == chunk - 1), base + step * (b + j)});
            b += chunk;
        end
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 400 && obs_q.size() < n; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        for (int p = 0; p < 4; p++) exp_seq[p] = 16'd0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int p = 0; p < 4; p++) exp_seq[p] = 16'd0;
        repeat (2) @(posedge clk);
        #2;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        tests++; if ({m_tdata, m_tkeep, m_tlast} !== 34'd0) begin fails++; $display("FAIL reset_data got %h want 0", {m_tdata, m_tkeep, m_tlast}); end
        tests++; if (m_grant !== 4'd0) begin fails++; $display("FAIL reset_grant got %b want 0000", m_grant); end
        tests++; if ({m_trunc, m_tcnt} !== 17'd0) begin fails++; $display("FAIL reset_trunc got %h want 0", {m_trunc, m_tcnt}); end
        tests++; if (m_rdy !== 4'd0) begin fails++; $display("FAIL reset_tready got %b want 0000", m_rdy); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests++; if ({m_tvalid, m_grant} !== 5'd0) begin fails++; $display("FAIL idle_quiet got %b want 00000", {m_tvalid, m_grant}); end
    endtask

    task automatic test_basic();
        logic [33:0] e, o;
        int n, lat;
        do_reset();
        send(2, 3, 32'h11, 32'h11, 16);
        wait_out(exp_q.size());
        lat = first_vld - tv_cyc;
        tests++; if (lat != 2) begin fails++; $display("FAIL basic_latency got %0d want 2", lat); end
        n = exp_q.size();
        send(2, 1, 32'h44, 32'h0, 16);
        wait_out(exp_q.size());
        tests++; if (gnt_q.size() != 2 || gnt_q[0] !== 4'b0100) begin fails++; $display("FAIL basic_grant got %0d grants want two of 0100", gnt_q.size()); end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL basic_beat[%0d] got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL basic_beat[%0d] got %h want %h (first pkt %0d beats)", i, o, e, n); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL basic_extra got %0d beats want 0", obs_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [33:0] e, o;
        logic [3:0]  eg;
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++)
                send(p, 2, 32'h1000_0000 * p + 32'h100 * k, 32'h1, 16);
        wait_out(exp_q.size());
        for (int k = 0; k < 8; k++) begin
            eg = 4'b0001 << (k % 4);
            tests++;
            if (gnt_q.size() == 0) begin fails++; $display("FAIL rr_grant[%0d] got none want %b", k, eg); end
            else if (gnt_q[0] !== eg) begin fails++; $display("FAIL rr_grant[%0d] got %b want %b", k, gnt_q[0], eg); void'(gnt_q.pop_front()); end
            else void'(gnt_q.pop_front());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL rr_beat[%0d] got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL rr_beat[%0d] got %h want %h", i, o, e); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL rr_extra got %0d beats want 0", obs_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [33:0] e, o;
        do_reset();
        bp_mode = 1'b1;
        send(1, 5, 32'h500, 32'h1, 16);
        wait_out(exp_q.size());
        bp_mode = 1'b0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL bp_beat[%0d] got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL bp_beat[%0d] got %h want %h", i, o, e); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL bp_extra got %0d beats want 0", obs_q.size()); end
        tests++; if (stall_viol != 0) begin fails++; $display("FAIL bp_stable got %0d changes while stalled want 0", stall_viol); end
        tests++; if (stall_cycles == 0) begin fails++; $display("FAIL bp_stalled got 0 stall cycles want >0"); end
    endtask

    task automatic test_truncate();
        logic [33:0] e, o;
        sel = 1'b1;
        do_reset();
        send(1, 6, 32'h61, 32'h1, 4);
        wait_out(exp_q.size());
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL trunc_beat[%0d] got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL trunc_beat[%0d] got %h want %h", i, o, e); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL trunc_extra got %0d beats want 0", obs_q.size()); end
        tests++; if (trunc_pulses != 1) begin fails++; $display("FAIL trunc_pulse got %0d want 1", trunc_pulses); end
        tests++; if (m_tcnt !== 16'd1) begin fails++; $display("FAIL trunc_count got %0d want 1", m_tcnt); end
        tests++; if (gnt_q.size() != 2) begin fails++; $display("FAIL trunc_rearb got %0d grants want 2", gnt_q.size()); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [33:0] e, o;
        do_reset();
        send(0, 4, 32'h700, 32'h1, 16);
        for (int c = 0; c < 200 && obs_q.size() < TAG_EN + 2; c++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== 35'd0) begin fails++; $display("FAIL midrst_out got %h want 0", {m_tvalid, m_tlast, m_tkeep, m_tdata}); end
        tests++; if ({m_grant, m_rdy} !== 8'd0) begin fails++; $display("FAIL midrst_grant got %h want 0", {m_grant, m_rdy}); end
        exp_q.delete();
        for (int p = 0; p < 4; p++) exp_seq[p] = 16'd0;
        @(posedge clk); #2;
        rst = 1'b0;
        send(0, 2, 32'h800, 32'h1, 16);
        wait_out(exp_q.size());
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL midrst_beat[%0d] got none want %h", i, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL midrst_beat[%0d] got %h want %h", i, o, e); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL midrst_extra got %0d beats want 0", obs_q.size()); end
    endtask

    initial begin
        sel = 1'b0;
        bp_mode = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_truncate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no finish want finish within 40000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mrr_pathway_stream_merge.md
# mrr_pathway_stream_merge

Parametrised N-pathway output merger for the MRR gateway decode datapath. It collects the per-pathway 32-bit packet streams produced by the loopback/decode pathways into one AXI-Stream output. Arbitration is round-robin and packet-atomic. Each packet can optionally be prefixed with a tag word carrying the pathway index and a per-pathway sequence number. A beat-count guard truncates runaway packets so one stuck pathway cannot monopolise the output.

## Interface
Parameters:
- NUM_PATHWAYS, 4: number of input pathways, legal range 1..16.
- PATHWAY_IDX_WIDTH, 2: width of the pathway index; must be ≥ clog2(NUM_PATHWAYS), and is 1 when NUM_PATHWAYS = 1.
- DATA_WIDTH, 32: beat width, ≥ 32.
- MAX_PKT_BEATS, 1024: maximum data beats per packet before forced truncation, ≥ 2.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- i_tdata  in  DATA_WIDTH*NUM_PATHWAYS  per-pathway data; pathway p occupies bits [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH].
- i_tkeep  in  NUM_PATHWAYS  per-pathway keep.
- i_tlast  in  NUM_PATHWAYS  per-pathway end of packet.
- i_tvalid  in  NUM_PATHWAYS  per-pathway valid.
- i_tready  out  NUM_PATHWAYS  per-pathway ready.
- o_tdata  out  DATA_WIDTH  merged data.
- o_tkeep  out  1  merged keep.
- o_tlast  out  1  merged end of packet.
- o_tvalid  out  1  merged valid.
- o_tready  in  1  downstream ready.
- o_grant  out  NUM_PATHWAYS  one-hot grant for the current packet; all zero in IDLE.
- o_truncate  out  1  one-cycle pulse when a packet is force-terminated.
- o_truncate_count  out  16  saturating count of truncations.

## Operation
- State machine: IDLE, TAG, DATA.
- IDLE
  - If no i_tvalid bit is set, remain in IDLE.
  - Otherwise, grant the first valid pathway searching upward from last_grant+1, wrapping modulo NUM_PATHWAYS.
  - Register the grant and last_grant, clear the beat counter, then go to TAG (macro defined) or DATA (macro undefined).
  - After reset, last_grant = NUM_PATHWAYS-1, so pathway 0 has priority first.
- TAG
  - When the output register is free (!o_tvalid || o_tready), load the tag word with o_tkeep=1 and o_tlast=0.
  - Tag word layout, in the low 32 bits: [31:24]=8'hA5, [23:16]=granted index (zero-extended), [15:0]=seq[grant]. Bits above 31 are 0.
  - Increment seq[grant]; it wraps 0xFFFF→0.
  - Go to DATA.
- DATA
  - i_tready[g] = (!o_tvalid || o_tready) for the granted pathway g; i_tready is 0 for all others and in all other states.
  - Each accepted beat is copied into the output register and the beat counter increments.
  - When the accepted beat has i_tlast=1, return to IDLE.
  - When the accepted beat is beat number MAX_PKT_BEATS without i_tlast: force o_tlast=1, pulse o_truncate, increment o_truncate_count (saturating at 0xFFFF), and return to IDLE. The pathway's remaining beats are arbitrated later as a new packet.
- Output register: o_tvalid is set on load and cleared on (o_tvalid && o_tready) when no new load occurs in the same cycle.
- o_tvalid never drops while o_tready=0, and o_tdata, o_tkeep and o_tlast are stable while stalled.

## Timing
- Reset values: o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0, o_grant=0, o_truncate=0, o_truncate_count=0, i_tready=0, all seq=0, state=IDLE.
- Reset asserted mid-packet aborts immediately. Downstream sees o_tvalid drop asynchronously; a partial packet is not completed.
- Latency from i_tvalid (pathway idle, output free) to first o_tvalid:
  - 2 cycles with tag: IDLE grant, then TAG load.
  - 2 cycles without tag: IDLE grant, then DATA load of the first beat.
- Steady state is 1 beat per cycle with o_tready held high. There is one bubble cycle per packet boundary for IDLE arbitration.
- A pathway deasserting i_tvalid mid-packet holds the grant indefinitely, subject only to the MAX_PKT_BEATS guard, which counts accepted beats only.
- Valid bits changing in the IDLE cycle are sampled that cycle; the grant is not revisited until the packet ends.

## Configuration
- MRR_MERGE_TAG_EN
  - Defined: the TAG state and per-pathway 16-bit sequence counters are present, and every packet is prefixed by one tag word.
  - Undefined: TAG state and counters are removed; IDLE goes directly to DATA and output packets are byte-identical to input packets.
  - Arbitration and truncation are unchanged in both cases.

## Test plan
- Tag enabled, NUM_PATHWAYS=4. Pathway 2 sends 3 beats 0x11,0x22,0x33 with tlast on the last.
  - Required output: 0xA5020000, 0x11, 0x22, 0x33, with o_tlast only on 0x33. A second packet from pathway 2 is tagged 0xA5020001.
- All four pathways hold 2-beat packets valid continuously from reset.
  - Required: grant order 0,1,2,3,0; no beat from one pathway is interleaved into another's packet.
- Output backpressure: o_tready toggles 1,0,0,1,… during a 5-beat packet.
  - Required: all beats appear in order with no loss or duplication, and o_tdata is stable while o_tready=0.
- MAX_PKT_BEATS=4, pathway 1 sends 6 beats with tlast on beat 6.
  - Required: the first packet ends at input beat 4 with forced o_tlast, o_truncate pulses once, o_truncate_count=1, and beats 5–6 are then re-arbitrated as a new packet.
- Assert rst for 1 cycle mid-packet (beat 2 of 4).
  - Required: all outputs return to their reset values, and the next packet from pathway 0 is tagged seq 0.
- Macro undefined, same stimulus as the first scenario.
  - Required: output is exactly 0x11,0x22,0x33, with first o_tvalid 2 cycles after i_tvalid.
